eu_iqueue: RTL
==============

// Module: eu_iqueue
// PURPOSE
//  Per-execution-unit instruction queue on the backend dispatch bus.
//  - Snoops all NUM_PARALLEL_INSTR_DISPATCHES dispatch lanes and captures lanes whose allocated EU index equals EU_IDX.
//  - Buffers captured lanes in program (lane) order and issues them one per cycle, in order, to its execution unit over valid/ready.
//  - Sits directly downstream of front-end dispatch. One instance per EU; all instances' dispatch_ready_o are ANDed into the shared bus ready.
// PARAMETERS
//  EU_IDX                         0                                 index of the owning EU; width LOG2_NUM_EXEC_UNITS
//  LOG2_DEPTH                     3                                 queue depth = 2**LOG2_DEPTH entries; DEPTH >= NUM_PARALLEL_INSTR_DISPATCHES
//  NUM_PARALLEL_INSTR_DISPATCHES  `NUM_PARALLEL_INSTR_DISPATCHES    dispatch lanes (localparam from design_parameters.sv)
// PORTS
//  clk                     in   1                                  clock, all state on rising edge
//  reset                   in   1                                  asynchronous, active-high reset
//  flush_i                 in   1                                  synchronous queue clear (pipeline flush)
//  instr_dispatch_i        in   type_iqueue_entry [NPD]            dispatch bus entries
//  instr_dispatch_valid_i  in   1 [NPD]                            per-lane valid
//  dispatched_instr_alloc_euidx_i in LOG2_NUM_EXEC_UNITS [NPD]     per-lane target EU
//  dispatch_fire_i         in   1                                  global bus handshake (valid-qualifying ANDed ready)
//  dispatch_ready_o        out  1                                  this queue can absorb NPD entries
//  issue_instr_o           out  type_iqueue_entry                  head entry to EU
//  issue_valid_o           out  1                                  head entry valid
//  issue_ready_i           in   1                                  EU accepts head
//  occupancy_o             out  LOG2_DEPTH+1                       current entry count
// BEHAVIOUR
//  - Reset (async assert, sync use): head=tail=count=0.
//    Outputs after reset: issue_valid_o=0, issue_instr_o='0, occupancy_o=0, dispatch_ready_o=1. Storage array is not reset.
//  - Lane k is captured iff dispatch_fire_i && instr_dispatch_valid_i[k] && alloc_euidx[k]==EU_IDX.
//    Valid lanes with dispatch_fire_i=0 are ignored.
//  - Captured lanes are written to consecutive slots from tail in ascending k, skipping non-captured lanes.
//    tail += number captured (0..NPD), mod DEPTH, wraps naturally.
//  - dispatch_ready_o = (DEPTH - count) >= NPD; registered-state-only, no combinational path from any input.
//    Guarantees no overflow regardless of same-cycle pop.
//  - issue_valid_o = (count != 0). issue_instr_o = mem[head] when valid, else '0.
//    Data visible the cycle after write: push-to-issue latency is 1 cycle; no bypass.
//  - Pop when issue_valid_o && issue_ready_i: head += 1 mod DEPTH.
//    issue_instr_o/issue_valid_o hold stable while issue_ready_i=0.
//  - Simultaneous push and pop: count_next = count + npush - pop. Empty queue with push: no pop that cycle (valid was 0).
//  - flush_i: highest priority. Next cycle head=tail=count=0, same-cycle pushes and pops discarded.
//  - Reset mid-operation: all contents dropped immediately; no partial issue.
//  - Assertions: count <= DEPTH; no pop when empty; no push when dispatch_fire_i && !dispatch_ready_o.
// STRUCTURE
//  - pkg_dtypes: type_iqueue_entry (existing).
//  - design_parameters.sv: NUM_PARALLEL_INSTR_DISPATCHES and LOG2_NUM_EXEC_UNITS macros.
//  - Sub-module eu_iqueue_lane_compact: turns NPD lane-select bits into per-lane write offsets (prefix popcount) and total push count.
//  - Top level holds the storage array, pointers, count and the issue port.
// TESTING
//  1 reset -> issue_valid_o=0, occupancy_o=0, dispatch_ready_o=1; assert reset while count=3 -> all zero the same cycle.
//  2 EU_IDX=2, NPD=2: fire with lanes {0:eu2 A, 1:eu2 B}, issue_ready_i=1 -> A issued cycle+1, B cycle+2, occupancy 2->1->0.
//  3 lane0 to eu1, lane1 to eu2 (A1, B2) -> only B2 captured, occupancy_o=1; valid lanes with dispatch_fire_i=0 -> no capture.
//  4 DEPTH=8, NPD=2, issue_ready_i=0: fill 6 -> dispatch_ready_o=1; fill 7 -> 0.
//    Release ready -> drains in order, ready returns at count 6, tail/head wrap past slot 7 with order intact.
//  5 count=4, push 2 while popping 1 -> occupancy_o=5 next cycle, head entry advanced by one.
//  6 count=5 with push and pop pending, flush_i=1 -> next cycle occupancy_o=0, issue_valid_o=0, and a later push issues correctly.

Source files
------------

// File: rtl/eu_iqueue_pkg.sv
// Shared types and dispatch-bus dimensions for the per-EU instruction queue.
// The queue entry is a fixed 32-bit record: ROB tag plus opaque payload.
package eu_iqueue_pkg;

    localparam int DISPATCH_LANES      = 2;
    localparam int LOG2_NUM_EXEC_UNITS = 2;

    typedef struct packed {
        logic [5:0]  rob_tag;
        logic [25:0] payload;
    } type_iqueue_entry;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/eu_iqueue_checker.sv
// Protocol and occupancy invariants for eu_iqueue, kept apart from the datapath.
module eu_iqueue_checker #(
    parameter int CNTW  = 4,
    parameter int DEPTH = 8
) (
    input logic            clk,
    input logic            reset,
    input logic [CNTW-1:0] count,
    input logic            pop,
    input logic            push_any,
    input logic            fire,
    input logic            ready
);

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CNTW'(DEPTH));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && (count == '0)));

    a_no_push_unready: assert property (@(posedge clk) disable iff (reset)
        !(fire && !ready && push_any));

endmodule

// File: rtl/eu_iqueue_lane_compact.sv
// Turns per-lane select bits into packed write offsets (exclusive prefix popcount)
// plus the total number of selected lanes.
module eu_iqueue_lane_compact
    import eu_iqueue_pkg::*;
#(
    parameter int NPD = DISPATCH_LANES,
    parameter int CW  = count_width(NPD)
) (
    input  logic [NPD-1:0]         sel,
    output logic [NPD-1:0][CW-1:0] offset,
    output logic [CW-1:0]          total
);

    logic [CW-1:0] acc_s;

    // Each selected lane lands right after every earlier selected lane.
    always_comb begin
        acc_s  = '0;
        offset = '0;
        for (int k = 0; k < NPD; k++) begin
            offset[k] = acc_s;
            acc_s     = acc_s + CW'(sel[k]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/eu_iqueue.sv
// Per-execution-unit in-order instruction queue: snoops the dispatch bus, captures
// lanes targeted at EU_IDX in lane order and issues them one per cycle.
module eu_iqueue
    import eu_iqueue_pkg::*;
#(
    parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX = '0,
    parameter int LOG2_DEPTH                    = 3,
    parameter int NUM_PARALLEL_INSTR_DISPATCHES = DISPATCH_LANES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  type_iqueue_entry               instr_dispatch_i [NUM_PARALLEL_INSTR_DISPATCHES],
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0] instr_dispatch_valid_i,
    input  logic [LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_i [NUM_PARALLEL_INSTR_DISPATCHES],
    input  logic                           dispatch_fire_i,
    output logic                           dispatch_ready_o,
    output type_iqueue_entry               issue_instr_o,
    output logic                           issue_valid_o,
    input  logic                           issue_ready_i,
    output logic [LOG2_DEPTH:0]            occupancy_o
);

    localparam int NPD   = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int CNTW  = LOG2_DEPTH + 1;
    localparam int CW    = count_width(NPD);

    type_iqueue_entry        mem_r [DEPTH];
    logic [LOG2_DEPTH-1:0]   head_r;
    logic [LOG2_DEPTH-1:0]   tail_r;
    logic [CNTW-1:0]         count_r;

    logic [NPD-1:0]          sel_s;
    logic [NPD-1:0][CW-1:0]  offset_s;
    logic [CW-1:0]           npush_s;
    logic                    pop_s;
    logic [LOG2_DEPTH-1:0]   waddr_s [NPD];

    // Lane capture qualification and compacted write addresses.
    always_comb begin
        for (int k = 0; k < NPD; k++) begin
            sel_s[k]   = dispatch_fire_i && instr_dispatch_valid_i[k] &&
                         (dispatched_instr_alloc_euidx_i[k] == EU_IDX);
            waddr_s[k] = tail_r + LOG2_DEPTH'(offset_s[k]);
        end
    end

    eu_iqueue_lane_compact #(
        .NPD (NPD),
        .CW  (CW)
    ) u_lane_compact (
        .sel    (sel_s),
        .offset (offset_s),
        .total  (npush_s)
    );

    assign pop_s = issue_valid_o && issue_ready_i;

    // Storage is not reset; pointer state alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            for (int k = 0; k < NPD; k++) begin
                if (sel_s[k]) begin
                    mem_r[waddr_s[k]] <= instr_dispatch_i[k];
                end
            end
        end
    end

    // Pointer and count state; flush discards same-cycle pushes and pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + LOG2_DEPTH'(pop_s);
            tail_r  <= tail_r + LOG2_DEPTH'(npush_s);
            count_r <= count_r + CNTW'(npush_s) - CNTW'(pop_s);
        end
    end

    // Outputs depend on registered state only, so the shared bus ready has no input path.
    assign dispatch_ready_o = (CNTW'(DEPTH) - count_r) >= CNTW'(NPD);
    assign issue_valid_o    = (count_r != '0);
    assign occupancy_o      = count_r;

    // Head entry is driven only while valid, zero otherwise.
    always_comb begin
        if (issue_valid_o) begin
            issue_instr_o = mem_r[head_r];
        end else begin
            issue_instr_o = '0;
        end
    end

    eu_iqueue_checker #(
        .CNTW  (CNTW),
        .DEPTH (DEPTH)
    ) u_checker (
        .clk      (clk),
        .reset    (reset),
        .count    (count_r),
        .pop      (pop_s),
        .push_any (|sel_s),
        .fire     (dispatch_fire_i),
        .ready    (dispatch_ready_o)
    );

endmodule
